// File: rtl/hack_pkg.sv
// Shared types and default sizes for the Hack data-memory arbiter.
package hack_pkg;

  localparam int unsigned HACK_ADDR_W   = 15;
  localparam int unsigned HACK_DATA_W   = 16;
  localparam int unsigned HACK_MAX_WAIT = 4;
  // Wide enough for the largest legal MAX_WAIT (15).
  localparam int unsigned HACK_CNT_W    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } grant_e;

endpackage

// File: rtl/hack_arb_pick.sv
// Arbitration decision between CPU and DMA, plus the DMA starvation counter.
// Optional feature macro: HACK_ARB_FAIRNESS_EN (wait counter forcing the DMA
// after MAX_WAIT CPU grants while the DMA waits). Without it: strict CPU priority.
module hack_arb_pick
  import hack_pkg::*;
#(
  parameter int unsigned MAX_WAIT = HACK_MAX_WAIT
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   arb_en,
  input  logic   cpu_req,
  input  logic   dma_req,
  output grant_e gnt_c,
  output logic   forced_c
);

`ifdef HACK_ARB_FAIRNESS_EN
  logic [HACK_CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // DMA is forced only while it is actually waiting, so a departed DMA never blocks the CPU.
  always_comb begin
    forced_c = dma_req && (wait_cnt_q == HACK_CNT_W'(MAX_WAIT));
  end

  // Saturating starvation count: bump on CPU grants over a waiting DMA, clear on DMA grants.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (arb_en) begin
      if (gnt_c == GNT_DMA) begin
        wait_cnt_d = '0;
      end else if ((gnt_c == GNT_CPU) && dma_req &&
                   (wait_cnt_q != HACK_CNT_W'(MAX_WAIT))) begin
        wait_cnt_d = wait_cnt_q + HACK_CNT_W'(1);
      end
    end
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_c;

  // Strict CPU priority: nothing ever forces the DMA.
  always_comb begin
    forced_c = 1'b0;
    unused_c = &{1'b0, clk, reset, arb_en, HACK_CNT_W'(MAX_WAIT)};
  end
`endif

  // CPU first unless the DMA is forced, then DMA, else nobody.
  always_comb begin
    gnt_c = GNT_NONE;
    if (cpu_req && !forced_c) begin
      gnt_c = GNT_CPU;
    end else if (dma_req) begin
      gnt_c = GNT_DMA;
    end
  end

endmodule

// File: rtl/hack_mem_arbiter.sv
// Two-port (CPU/DMA) arbiter in front of a single-port synchronous Hack RAM.
// One access every two cycles: grant edge -> RAM cycle -> RESP (ack registered).
// Optional feature macro: HACK_ARB_FAIRNESS_EN (see hack_arb_pick).
module hack_mem_arbiter
  import hack_pkg::*;
#(
  parameter int unsigned ADDR_W   = HACK_ADDR_W,
  parameter int unsigned DATA_W   = HACK_DATA_W,
  parameter int unsigned MAX_WAIT = HACK_MAX_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  logic                mem_en_q, mem_en_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                acc_we_q, acc_we_d;
  logic                acc_dma_q, acc_dma_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                dma_ack_q, dma_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dma_rdata_q, dma_rdata_d;
  logic                arb_en_c;
  grant_e              gnt_c;
  logic                forced_c;

  hack_arb_pick #(
    .MAX_WAIT (MAX_WAIT)
  ) u_pick (
    .clk      (clk),
    .reset    (reset),
    .arb_en   (arb_en_c),
    .cpu_req  (cpu_req),
    .dma_req  (dma_req),
    .gnt_c    (gnt_c),
    .forced_c (forced_c)
  );

  // Next-state, grant capture and response logic.
  always_comb begin
    state_d     = state_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    acc_we_d    = acc_we_q;
    acc_dma_d   = acc_dma_q;
    cpu_ack_d   = 1'b0;
    dma_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    arb_en_c    = 1'b0;

    case (state_q)
      CPU_ACC, DMA_ACC: begin
        state_d = RESP;
      end
      default: begin
        // RAM data from the previous access cycle is valid here.
        if (state_q == RESP) begin
          if (acc_dma_q) begin
            dma_ack_d = 1'b1;
            if (!acc_we_q) dma_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!acc_we_q) cpu_rdata_d = mem_rdata;
          end
        end

        arb_en_c = 1'b1;
        case (gnt_c)
          GNT_CPU: begin
            state_d     = CPU_ACC;
            mem_en_d    = 1'b1;
            mem_we_d    = cpu_we;
            mem_addr_d  = cpu_addr;
            mem_wdata_d = cpu_wdata;
            acc_we_d    = cpu_we;
            acc_dma_d   = 1'b0;
          end
          GNT_DMA: begin
            state_d     = DMA_ACC;
            mem_en_d    = 1'b1;
            mem_we_d    = dma_we;
            mem_addr_d  = dma_addr;
            mem_wdata_d = dma_wdata;
            acc_we_d    = dma_we;
            acc_dma_d   = 1'b1;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    endcase
  end

  // State and output registers; reset clears everything, aborting any access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      acc_we_q    <= 1'b0;
      acc_dma_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      acc_we_q    <= acc_we_d;
      acc_dma_q   <= acc_dma_d;
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_hack_mem_arbiter.sv
// Directed self-checking bench for hack_mem_arbiter with a behavioural sync RAM.
module tb_hack_mem_arbiter;
  import hack_pkg::*;

  localparam int unsigned AW = 15;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          preload;

  int n_checks = 0;
  int n_errors = 0;
  int n_viol   = 0;

  hack_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_ack   (cpu_ack),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_ack   (dma_ack),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, synchronous read with one-cycle latency.
  always @(posedge clk) begin
    if (preload) begin
      ram[1]  <= 16'h0000;
      ram[2]  <= 16'h2222;
      ram[3]  <= 16'h1234;
      ram[5]  <= 16'h0000;
      ram[15] <= 16'hABCD;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Continuous invariants: no write strobe without enable, never two acks.
  always @(negedge clk) begin
    if (mem_we && !mem_en) n_viol++;
    if (cpu_ack && dma_ack) n_viol++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int            n_a, n_b, n_g;
  logic [9:0]    seq;
  logic [9:0]    exp_seq;
  int            exp_dma_acks;

  initial begin
    reset = 1'b0; preload = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_rdata = '0;

    // Reset held with a CPU request pending.
    repeat (2) tick();
    preload = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(15);
    repeat (2) tick();
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_acks",      32'({cpu_ack, dma_ack}), 32'd0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_dma_rdata", 32'(dma_rdata), 32'd0);

    // Release; first edge must grant. This is also the CPU read of RAM[15].
    reset = 1'b1;
    tick();
    check("first_grant", 32'(mem_en),   32'd1);
    check("rd_addr",     32'(mem_addr), 32'd15);
    check("rd_we",       32'(mem_we),   32'd0);
    cpu_req = 1'b0;
    tick();
    check("rd_en_1cyc",  32'(mem_en),   32'd0);
    check("rd_ack_early",32'(cpu_ack),  32'd0);
    tick();
    check("rd_ack",      32'(cpu_ack),  32'd1);
    check("rd_data",     32'(cpu_rdata),32'hABCD);
    check("rd_dma_ack",  32'(dma_ack),  32'd0);
    tick();
    check("rd_ack_pulse",32'(cpu_ack),  32'd0);

    // CPU write of 0x000F to address 1.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(1); cpu_wdata = 16'h000F;
    tick();
    check("wr_en",    32'(mem_en),    32'd1);
    check("wr_we",    32'(mem_we),    32'd1);
    check("wr_addr",  32'(mem_addr),  32'd1);
    check("wr_wdata", 32'(mem_wdata), 32'h000F);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("wr_we_1cyc", 32'(mem_we), 32'd0);
    check("wr_ram",     32'(ram[1]), 32'h000F);
    tick();
    check("wr_ack",       32'(cpu_ack),   32'd1);
    check("wr_rdata_hold",32'(cpu_rdata), 32'hABCD);
    tick();
    check("wr_ack_pulse", 32'(cpu_ack),   32'd0);

    // DMA request pulsed for one cycle while the CPU owns the RAM.
    cpu_req = 1'b1; cpu_addr = AW'(2);
    tick();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_addr = AW'(7);
    tick();
    dma_req = 1'b0;
    n_a = 0; n_b = 0;
    repeat (6) begin
      tick();
      if (dma_ack) n_a++;
      if (mem_en)  n_b++;
    end
    check("drop_dma_ack", 32'(n_a), 32'd0);
    check("drop_mem_en",  32'(n_b), 32'd0);

    // Continuous contention: CPU reads addr 2, DMA reads addr 3.
    cpu_addr = AW'(2); dma_addr = AW'(3);
    cpu_req = 1'b1; dma_req = 1'b1;
    n_a = 0; n_g = 0; seq = '0;
    repeat (20) begin
      tick();
      if (mem_en) begin
        if (n_g < 10) seq[n_g] = (mem_addr == AW'(3));
        n_g++;
      end
      if (dma_ack) n_a++;
    end
    cpu_req = 1'b0; dma_req = 1'b0;
`ifdef HACK_ARB_FAIRNESS_EN
    exp_seq = 10'b10_0001_0000;
    exp_dma_acks = 1;
`else
    exp_seq = 10'b00_0000_0000;
    exp_dma_acks = 0;
`endif
    check("cont_grants",   32'(n_g), 32'd10);
    check("cont_seq",      32'(seq), 32'(exp_seq));
    check("cont_dma_acks", 32'(n_a), 32'(exp_dma_acks));
    repeat (4) tick();

    // Reset asserted during the RAM cycle of a CPU write.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = AW'(5); cpu_wdata = 16'h5555;
    tick();
    check("ab_we_before", 32'(mem_we), 32'd1);
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    check("ab_we_drop", 32'(mem_we),      32'd0);
    check("ab_en_drop", 32'(mem_en),      32'd0);
    check("ab_state",   32'(dut.state_q), 32'(IDLE));
    n_a = 0;
    repeat (2) begin
      tick();
      if (cpu_ack || dma_ack) n_a++;
    end
    reset = 1'b1;
    repeat (3) begin
      tick();
      if (cpu_ack || dma_ack) n_a++;
    end
    check("ab_no_ack",     32'(n_a),           32'd0);
    check("ab_state_post", 32'(dut.state_q),   32'(IDLE));
    check("ab_ram",        32'(ram[5]),        32'h0000);
    check("ab_rdata_clr",  32'(cpu_rdata),     32'h0000);

    check("invariants", 32'(n_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
